d_mem_axi_bridge: RTL
=====================

D_MEM_AXI_BRIDGE -- requirements
Module: d_mem_axi_bridge

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1, ID driven on arid/awid.
REQ-002 SHALL have parameter UNMAPPED_MASK, default 32'h1FFF_FFFF, physical mask for kseg0/kseg1 addresses.
REQ-003 SHALL have the following ports, one clock; reset is synchronous and active-high:
 - clk  in  1  sole clock, rising edge
 - rst  in  1  synchronous active-high reset
 - data_en  in  1  MEM-stage access request
 - data_wen  in  4  byte enables; 0 = load
 - data_addr  in  32  virtual byte address
 - data_wdata  in  32  store data, already lane-aligned
 - data_size  in  2  0 byte, 1 half, 2 word
 - longest_stall  in  1  global pipeline stall
 - data_rdata  out  32  loaded word
 - data_stall  out  1  access in progress
 - arid/araddr/arsize/arvalid  out  4/32/3/1; arready in 1
 - rdata in 32, rlast in 1, rvalid in 1; rready out 1
 - awid/awaddr/awsize/awvalid  out  4/32/3/1; awready in 1
 - wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready in 1
 - bvalid in 1; bready out 1
 - arlen/awlen tied 0, arburst/awburst tied 2'b01.

Function
REQ-004 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-005 IDLE SHALL go to RD_ADDR when data_en and data_wen==0, to WR_REQ when data_en and data_wen!=0, and stay otherwise.
REQ-006 RD_ADDR SHALL assert arvalid and go to RD_DATA on the cycle arvalid&arready.
REQ-007 RD_DATA SHALL assert rready, capture rdata into data_rdata on rvalid&rready, and go to DONE.
REQ-008 WR_REQ SHALL assert awvalid and wvalid, and drop each independently once accepted, using aw_done/w_done flags.
REQ-009 WR_REQ SHALL go to WR_RESP once both AW and W are accepted; acceptance may occur in the same cycle or in either order.
REQ-010 WR_RESP SHALL assert bready and go to DONE on bvalid.
REQ-011 DONE SHALL return to IDLE on the first cycle with longest_stall==0; the access SHALL NOT be reissued while the pipeline remains stalled.
REQ-012 data_stall SHALL be combinational and equal data_en & (state != DONE); it is high in the request's first IDLE cycle.
REQ-013 Read address SHALL be the word-aligned physical address {pa[31:2],2'b00} with arsize=3'b010.
REQ-014 Write address SHALL be the physical byte address; awsize SHALL equal {1'b0,data_size}; wstrb SHALL equal data_wen; wlast SHALL be 1.
REQ-015 Physical address SHALL be addr & UNMAPPED_MASK when addr[31:30]==2'b10, and addr unchanged otherwise.
REQ-016 Address, size, strobe and wdata SHALL be registered on the IDLE-exit cycle and held stable until DONE, independent of upstream changes.
REQ-017 data_rdata SHALL hold its value until the next read capture; write transactions SHALL NOT modify it.
REQ-018 rresp/bresp errors SHALL be ignored; the access completes normally.
REQ-019 Zero-wait slave: a load SHALL reach DONE 3 cycles after the request's first cycle, with data_stall high for exactly 3 cycles.

Reset
REQ-020 On rst: state=IDLE, all valid/ready outputs 0, aw_done=w_done=0, data_rdata=0, held registers 0.
REQ-021 Reset mid-transaction SHALL abandon the transaction (the slave is reset concurrently) and drive no valid on the following cycle.

Structure
REQ-022 A shared package SHALL hold the state enum, AXI size constants (SZ_BYTE/HALF/WORD) and the burst constant.
REQ-023 Address translation SHALL be one sub-module, addr_map, combinational, reused by the instruction-side bridge.

Verification
REQ-024 Load 0x8000_1004, arready/rvalid immediate, rdata=0xDEADBEEF -> araddr=0x0000_1004, data_rdata=0xDEADBEEF, data_stall high 3 cycles.
REQ-025 sb to 0xA000_0003, wen=4'b1000 -> awaddr=0x0000_0003, awsize=0, wstrb=4'b1000; awready 2 cycles before wready -> single AW and single W, then WR_RESP.
REQ-026 Load done while longest_stall is held high 5 more cycles -> state stays DONE, no second arvalid, data_stall=0.
REQ-027 Store with awready and wready in the same cycle -> WR_RESP next cycle; bvalid after 4 cycles -> DONE.
REQ-028 rst asserted in RD_DATA -> next cycle IDLE, rready=0, arvalid=0, data_rdata=0.
REQ-029 data_addr changes during RD_ADDR with arready delayed 3 cycles -> araddr stays at the original value.

Source files
------------

// File: rtl/d_mem_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-side memory bridge.
// The addr_map translator is shared with the instruction-side bridge.
package d_mem_axi_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;

    localparam logic [2:0] SZ_BYTE    = 3'b000;
    localparam logic [2:0] SZ_HALF    = 3'b001;
    localparam logic [2:0] SZ_WORD    = 3'b010;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_e;

    // Request fields captured when an access leaves IDLE
    typedef struct packed {
        logic [ADDR_W-1:0] pa;
        logic [1:0]        size;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/d_mem_axi_bridge_addr_map.sv
// Virtual-to-physical translation: kseg0/kseg1 are masked down to the
// physical window, every other segment passes through unchanged.
module addr_map
    import d_mem_axi_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] UNMAPPED_MASK = 32'h1FFF_FFFF
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr_c
);

    assign paddr_c = (vaddr[31:30] == 2'b10) ? (vaddr & UNMAPPED_MASK) : vaddr;

endmodule

// File: rtl/d_mem_axi_bridge.sv
// MEM-stage load/store to single-beat AXI bridge. One access in flight;
// the request is latched on IDLE exit and the FSM parks in DONE until the pipeline moves.
module d_mem_axi_bridge
    import d_mem_axi_bridge_pkg::*;
#(
    parameter logic [ID_W-1:0]   AXI_ID        = 4'd1,
    parameter logic [ADDR_W-1:0] UNMAPPED_MASK = 32'h1FFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_en,
    input  logic [STRB_W-1:0] data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [1:0]        data_size,
    input  logic              longest_stall,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_e            state_q, state_nx;
    req_t              req_q;
    logic              aw_done, w_done;
    logic [ADDR_W-1:0] pa_c;
    logic              unused_c;

    addr_map #(.UNMAPPED_MASK(UNMAPPED_MASK)) u_addr_map (
        .vaddr   (data_addr),
        .paddr_c (pa_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    // Request capture, per-channel write acceptance and load data
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            data_rdata <= '0;
        end else begin
            if (state_q == IDLE && data_en) begin
                req_q <= '{pa: pa_c, size: data_size, strb: data_wen, wdata: data_wdata};
            end
            if (state_q == WR_REQ) begin
                if (awvalid && awready) aw_done <= 1'b1;
                if (wvalid && wready)   w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (rvalid && rready) data_rdata <= rdata;
        end
    end

    always_comb begin
        state_nx = state_q;
        arvalid  = 1'b0;
        rready   = 1'b0;
        awvalid  = 1'b0;
        wvalid   = 1'b0;
        bready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_en) state_nx = (data_wen == '0) ? RD_ADDR : WR_REQ;
            end
            RD_ADDR: begin
                arvalid = 1'b1;
                if (arready) state_nx = RD_DATA;
            end
            RD_DATA: begin
                rready = 1'b1;
                if (rvalid) state_nx = DONE;
            end
            WR_REQ: begin
                awvalid = !aw_done;
                wvalid  = !w_done;
                // AW and W may complete together or in either order
                if ((aw_done || awready) && (w_done || wready)) state_nx = WR_RESP;
            end
            WR_RESP: begin
                bready = 1'b1;
                if (bvalid) state_nx = DONE;
            end
            DONE: begin
                if (!longest_stall) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign data_stall = data_en && (state_q != DONE);

    assign arid    = AXI_ID;
    assign araddr  = {req_q.pa[ADDR_W-1:2], 2'b00};
    assign arlen   = '0;
    assign arsize  = SZ_WORD;
    assign arburst = BURST_INCR;

    assign awid    = AXI_ID;
    assign awaddr  = req_q.pa;
    assign awlen   = '0;
    assign awsize  = {1'b0, req_q.size};
    assign awburst = BURST_INCR;
    assign wdata   = req_q.wdata;
    assign wstrb   = req_q.strb;
    assign wlast   = 1'b1;

    // Single-beat reads: rlast carries no extra information
    assign unused_c = rlast;

endmodule
